// File: rtl/key_event_ctrl.sv
// key_event_ctrl: turns debounced key edges from key_filter into single-cycle
// gesture pulses (short click, double click, long press, auto-repeat).
module key_event_ctrl #(
  parameter int unsigned LONG_CYC = 50_000_000,
  parameter int unsigned DBL_CYC  = 15_000_000,
  parameter int unsigned RPT_CYC  = 5_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic key_flag,
  input  logic key_state,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG_HOLD,
    WAIT_REL
  } state_t;

  // Last timer value of each timed interval; the timeout fires on that cycle.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(RPT_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;

  logic press_ev;
  logic rel_ev;

  assign press_ev = key_flag & ~key_state;
  assign rel_ev   = key_flag & key_state;

  // Next-state, timer and pulse decode; events take priority over timeouts.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (press_ev) state_d = PRESS1;
      end
      PRESS1: begin
        if (rel_ev) begin
          state_d = WAIT2;
        end else if (timer_q == LONG_LAST) begin
          state_d = LONG_HOLD;
          long_d  = 1'b1;
        end
      end
      WAIT2: begin
        if (press_ev) begin
          state_d = PRESS2;
        end else if (timer_q == DBL_LAST) begin
          state_d = IDLE;
          short_d = 1'b1;
        end
      end
      PRESS2: begin
        if (rel_ev) begin
          state_d  = IDLE;
          double_d = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          state_d  = WAIT_REL;
          double_d = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (rel_ev) begin
          state_d = IDLE;
        end else if (timer_q == RPT_LAST) begin
          repeat_d = 1'b1;
          timer_d  = '0;
        end
      end
      WAIT_REL: begin
        timer_d = '0;
        if (rel_ev) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Every state change restarts the interval timer.
    if (state_d != state_q) timer_d = '0;

    busy_d = (state_d != IDLE);
  end

  // State, timer and registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign short_pulse  = short_q;
  assign double_pulse = double_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_ctrl.sv
// Testbench for key_event_ctrl: directed gestures plus random key activity,
// compared every cycle against a timestamp-based gesture model.
module tb_key_event_ctrl;

  localparam int unsigned LONG = 1000;
  localparam int unsigned DBL  = 300;
  localparam int unsigned RPT  = 100;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  logic key_flag = 1'b0;
  logic key_state = 1'b1;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, busy;

  key_event_ctrl #(
    .LONG_CYC (LONG),
    .DBL_CYC  (DBL),
    .RPT_CYC  (RPT),
    .CNT_W    (26)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .key_flag     (key_flag),
    .key_state    (key_state),
    .short_pulse  (short_pulse),
    .double_pulse (double_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .busy         (busy)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: gesture phase plus the edge index at which it began.
  typedef enum {M_IDLE, M_FIRST, M_GAP, M_SECOND, M_HOLD, M_DRAIN} phase_t;
  phase_t ph = M_IDLE;
  int     t_enter = 0;
  logic   e_short, e_double, e_long, e_repeat;

  logic lvl = 1'b1;
  int cnt_s, cnt_d, cnt_l, cnt_r;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
    end
  endtask

  task automatic enter(input phase_t p);
    ph = p;
    t_enter = cyc;
  endtask

  // Elapsed edges since phase entry reaching the interval length is a timeout.
  task automatic model_step(input logic f, input logic s);
    logic pr, rl;
    int   e;
    pr = f & ~s;
    rl = f & s;
    e  = cyc - t_enter;
    e_short = 0; e_double = 0; e_long = 0; e_repeat = 0;
    case (ph)
      M_IDLE:   if (pr) enter(M_FIRST);
      M_FIRST:  if (rl) enter(M_GAP);
                else if (e == LONG) begin enter(M_HOLD); e_long = 1; end
      M_GAP:    if (pr) enter(M_SECOND);
                else if (e == DBL) begin enter(M_IDLE); e_short = 1; end
      M_SECOND: if (rl) begin enter(M_IDLE); e_double = 1; end
                else if (e == LONG) begin enter(M_DRAIN); e_double = 1; end
      M_HOLD:   if (rl) enter(M_IDLE);
                else if (e == RPT) begin t_enter = cyc; e_repeat = 1; end
      M_DRAIN:  if (rl) enter(M_IDLE);
      default:  enter(M_IDLE);
    endcase
  endtask

  task automatic step(input logic f, input logic s);
    logic e_busy;
    key_flag  = f;
    key_state = s;
    @(posedge Clk);
    cyc++;
    model_step(f, s);
    e_busy = (ph != M_IDLE);
    #1;
    check("outs", {3'b0, short_pulse, double_pulse, long_pulse, repeat_pulse, busy},
                  {3'b0, e_short, e_double, e_long, e_repeat, e_busy});
    cnt_s += int'(short_pulse);
    cnt_d += int'(double_pulse);
    cnt_l += int'(long_pulse);
    cnt_r += int'(repeat_pulse);
    key_flag = 1'b0;
  endtask

  task automatic press();
    lvl = 1'b0;
    step(1'b1, 1'b0);
  endtask

  task automatic release_key();
    lvl = 1'b1;
    step(1'b1, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, lvl);
  endtask

  task automatic clr();
    cnt_s = 0; cnt_d = 0; cnt_l = 0; cnt_r = 0;
  endtask

  task automatic expect_cnts(input string tag, input int s, input int d, input int l, input int r);
    check({tag, "_short"},  8'(cnt_s), 8'(s));
    check({tag, "_double"}, 8'(cnt_d), 8'(d));
    check({tag, "_long"},   8'(cnt_l), 8'(l));
    check({tag, "_repeat"}, 8'(cnt_r), 8'(r));
    check({tag, "_busy"},   {7'b0, busy}, 8'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("reset_outs", {3'b0, short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, 8'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Short click: short_pulse 300 edges after release
    clr(); press(); idle(199); release_key(); idle(310);
    expect_cnts("short", 1, 0, 0, 0);

    // Double click
    clr(); press(); idle(99); release_key(); idle(149); press(); idle(99); release_key(); idle(20);
    expect_cnts("double", 0, 1, 0, 0);

    // Long press with three repeats, silent release
    clr(); press(); idle(1349); release_key(); idle(20);
    expect_cnts("long", 0, 0, 1, 3);

    // Release on the long-timeout cycle wins: becomes a short click
    clr(); press(); idle(LONG - 1); release_key(); idle(310);
    expect_cnts("bnd_long", 1, 0, 0, 0);

    // Second press on the double-timeout cycle wins: becomes a double click
    clr(); press(); idle(49); release_key(); idle(DBL - 1); press(); idle(49); release_key(); idle(20);
    expect_cnts("bnd_dbl", 0, 1, 0, 0);

    // Second press held past LONG: double at timeout, silent release
    clr(); press(); idle(49); release_key(); idle(49); press(); idle(1199); release_key(); idle(20);
    expect_cnts("dbl_hold", 0, 1, 0, 0);

    // Asynchronous reset in LONG_HOLD, then a stray release
    clr(); press(); idle(1049);
    #2 Rst_n = 1'b0;
    #1;
    check("rst_async", {3'b0, short_pulse, double_pulse, long_pulse, repeat_pulse, busy}, 8'd0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b1;
    enter(M_IDLE);
    clr(); release_key(); idle(20);
    expect_cnts("post_rst", 0, 0, 0, 0);

    // Random key activity including boundary gaps and inconsistent edges
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        case ($urandom_range(0, 8))
          0: n = RPT - 2;  1: n = RPT - 1;  2: n = RPT;
          3: n = DBL - 2;  4: n = DBL - 1;  5: n = DBL;
          6: n = LONG - 2; 7: n = LONG - 1; default: n = LONG;
        endcase
      end else begin
        n = $urandom_range(0, 1200);
      end
      idle(n);
      if ($urandom_range(0, 7) == 0) step(1'b1, lvl);
      else if (lvl) press();
      else release_key();
    end
    if (!lvl) release_key();
    idle(400);
    check("final_busy", {7'b0, busy}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/key_event_ctrl.md
Name: key_event_ctrl

Overview:
- Gesture classifier sequenced by the debounced outputs of key_filter (key_flag, key_state).
- Turns debounced press/release edges into single-cycle command pulses: short press, double click, long press and auto-repeat while held.
- Sits between key_filter and the LED/application logic; one instance per filtered key.

Parameters:
LONG_CYC, 50_000_000, hold time in Clk cycles before long_pulse (1 s at 50 MHz)
DBL_CYC, 15_000_000, max gap in Clk cycles between first release and second press for a double click
RPT_CYC, 5_000_000, repeat_pulse period in Clk cycles while held after a long press
CNT_W, 26, timer width; must hold max(LONG_CYC, DBL_CYC, RPT_CYC)

Ports:
Clk  input  1  system clock
Rst_n  input  1  asynchronous active-low reset
key_flag  input  1  one-cycle strobe from key_filter on each debounced edge
key_state  input  1  debounced level from key_filter, 0 = pressed, valid whenever key_flag = 1
short_pulse  output  1  one-cycle pulse: single short click confirmed
double_pulse  output  1  one-cycle pulse: double click
long_pulse  output  1  one-cycle pulse: hold reached LONG_CYC
repeat_pulse  output  1  one-cycle pulse every RPT_CYC while held after long_pulse
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (Rst_n = 0, asynchronous): state = IDLE, timer = 0, all outputs 0. Reset mid-gesture aborts it; no pulse is emitted.
- Events:
  - press_ev = key_flag & ~key_state
  - rel_ev = key_flag & key_state
- Timer:
  - Counts +1 per cycle in timed states; cleared to 0 on every state transition.
  - tout(X) = (timer == X-1).
- Pulse outputs are registered. Each pulse is high for exactly one cycle, on the Clk edge that performs the triggering transition.
- Priority: when an event and a timeout occur in the same cycle, the event wins.
- States and transitions:
  - IDLE: press_ev -> PRESS1. rel_ev ignored.
  - PRESS1:
    - rel_ev -> WAIT2.
    - tout(LONG_CYC) -> LONG_HOLD, long_pulse.
  - WAIT2:
    - press_ev -> PRESS2.
    - tout(DBL_CYC) -> IDLE, short_pulse.
  - PRESS2:
    - rel_ev -> IDLE, double_pulse.
    - tout(LONG_CYC) -> WAIT_REL, double_pulse; no long_pulse.
  - LONG_HOLD:
    - rel_ev -> IDLE, no pulse.
    - tout(RPT_CYC) -> repeat_pulse, timer cleared, stay in LONG_HOLD.
    - First repeat_pulse occurs RPT_CYC cycles after long_pulse.
  - WAIT_REL: rel_ev -> IDLE; all else ignored.
- Inconsistent events are ignored and leave the state unchanged: press_ev in PRESS1, PRESS2, LONG_HOLD or WAIT_REL; rel_ev in WAIT2.
- Short click latency: short_pulse fires DBL_CYC cycles after the release edge.
- At most one pulse output is high in any cycle.
- busy is registered. It equals (state != IDLE) after the edge and is 0 in the cycle after the final pulse.

Test Plan (sim params LONG_CYC=1000, DBL_CYC=300, RPT_CYC=100; stimulus drives key_flag/key_state directly):
- Short click: press, release after 200 cycles -> short_pulse once, 300 cycles after release; no other pulses; busy returns to 0.
- Double click: press 100, release, press again 150 cycles later, release after 100 -> double_pulse on the edge after the second release; short_pulse never asserted.
- Long + repeat: press, hold 1350 cycles, release -> long_pulse at cycle 1000; repeat_pulse at 1100, 1200 and 1300; nothing on release; IDLE.
- Boundary: release in exactly the cycle where timer==LONG_CYC-1 -> WAIT2 and no long_pulse. Second press in the cycle where timer==DBL_CYC-1 in WAIT2 -> PRESS2 and no short_pulse.
- Second press held 1200 cycles -> double_pulse at 1000 cycles into the hold; release then returns to IDLE with no further pulses.
- Reset mid-LONG_HOLD: assert Rst_n low asynchronously between edges -> outputs 0 immediately, state IDLE. A stray rel_ev after reset produces no pulse.
